// File: rtl/ising_run_ctrl.sv
// Host-side sequencer for ising_axi: drains buffered couplings into symmetric weight writes,
// programs the counters, launches a run and thresholds the phases. Optional: ISING_RUN_CTRL_RESTART_EN.
module ising_run_ctrl #(
    parameter int unsigned N                = 8,
    parameter int unsigned NUM_WEIGHTS      = 3,
    parameter int unsigned DEPTH            = 16,
    parameter int unsigned RUN_CYCLES       = 1000,
    parameter logic [31:0] START_WORD       = 32'h0000_0010,
`ifdef ISING_RUN_CTRL_RESTART_EN
    parameter logic [31:0] RESTART_WORD     = 32'h0000_0200,
`endif
    parameter logic [31:0] WEIGHT_ADDR_BASE = 32'h0001_0000,
    parameter logic [31:0] CTR_CUTOFF_ADDR  = 32'h0000_0004,
    parameter logic [31:0] CTR_MAX_ADDR     = 32'h0000_0008,
    parameter logic [31:0] START_ADDR       = 32'h0000_0000,
    parameter logic [31:0] PHASE_ADDR_BASE  = 32'h0000_0100,
    localparam int unsigned IW              = (N > 1) ? $clog2(N) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpl_valid,
    output logic                   cpl_ready,
    input  logic [IW-1:0]          cpl_i,
    input  logic [IW-1:0]          cpl_j,
    input  logic [NUM_WEIGHTS-1:0] cpl_w,
    input  logic [31:0]            cutoff,
    input  logic [31:0]            ctr_max,
    input  logic                   go,
    output logic                   busy,
    output logic                   done,
    output logic [N-1:0]           spins,
    output logic                   err,
    output logic                   wready,
    output logic [31:0]            wr_addr,
    output logic [31:0]            wdata,
    output logic [31:0]            araddr_q,
    input  logic [31:0]            rdata
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = 2 * IW + NUM_WEIGHTS;

    typedef enum logic [3:0] {
        IDLE, DRAIN, CUT, MAX, START, WAIT,
`ifdef ISING_RUN_CTRL_RESTART_EN
        RESTART, WAIT2,
`endif
        READ, CAP, DONE
    } state_t;

    state_t                   state, state_d;
    logic [EW-1:0]            fifo_mem [DEPTH];
    logic [AW-1:0]            wr_ptr, rd_ptr;
    logic [CW-1:0]            count, count_d;
    logic                     push, pop, drop, entry_ok;
    logic [IW-1:0]            head_i, head_j;
    logic [NUM_WEIGHTS-1:0]   head_w;
    logic                     phase_b, phase_b_d;
    logic [31:0]              cnt, cnt_d;
    logic [IW-1:0]            k, k_d;
    logic [31:0]              cutoff_q, ctr_max_q;
    logic                     go_acc, err_d;
    logic                     wr_en_c;
    logic [31:0]              wr_addr_c, wdata_c, araddr_c;
    logic [N-1:0]             spins_d;

    function automatic logic [31:0] weight_addr(input logic [IW-1:0] r, input logic [IW-1:0] c);
        return WEIGHT_ADDR_BASE + (32'(r) << 2) + (32'(c) << 13);
    endfunction

    // Spin k lives at the mirrored phase slot N-1-k.
    function automatic logic [31:0] phase_addr(input logic [IW-1:0] s);
        return PHASE_ADDR_BASE + ((32'(N - 1) - 32'(s)) << 2);
    endfunction

    assign {head_i, head_j, head_w} = fifo_mem[rd_ptr];
    assign entry_ok = (32'(cpl_i) < N) && (32'(cpl_j) < N);
    assign push     = cpl_valid && cpl_ready && entry_ok;
    assign drop     = cpl_valid && cpl_ready && !entry_ok;

    always_comb begin
        count_d = count;
        if (push && !pop)      count_d = count + CW'(1);
        else if (pop && !push) count_d = count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {cpl_i, cpl_j, cpl_w};
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state;
        phase_b_d = phase_b;
        cnt_d     = cnt;
        k_d       = k;
        pop       = 1'b0;
        go_acc    = 1'b0;
        wr_en_c   = 1'b0;
        wr_addr_c = wr_addr;
        wdata_c   = wdata;
        araddr_c  = araddr_q;
        spins_d   = spins;
        case (state)
            IDLE: begin
                if (go) begin
                    go_acc    = 1'b1;
                    phase_b_d = 1'b0;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                if (phase_b) begin
                    wr_en_c   = 1'b1;
                    wr_addr_c = weight_addr(head_j, head_i);
                    wdata_c   = 32'(head_w);
                    pop       = 1'b1;
                    phase_b_d = 1'b0;
                end else if (count == '0) begin
                    state_d = CUT;
                end else begin
                    wr_en_c   = 1'b1;
                    wr_addr_c = weight_addr(head_i, head_j);
                    wdata_c   = 32'(head_w);
                    if (head_i == head_j) pop       = 1'b1;
                    else                  phase_b_d = 1'b1;
                end
            end
            CUT: begin
                wr_en_c   = 1'b1;
                wr_addr_c = CTR_CUTOFF_ADDR;
                wdata_c   = cutoff_q;
                state_d   = MAX;
            end
            MAX: begin
                wr_en_c   = 1'b1;
                wr_addr_c = CTR_MAX_ADDR;
                wdata_c   = ctr_max_q;
                state_d   = START;
            end
            START: begin
                wr_en_c   = 1'b1;
                wr_addr_c = START_ADDR;
                wdata_c   = START_WORD;
                cnt_d     = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                if (cnt == 32'(RUN_CYCLES - 1)) begin
`ifdef ISING_RUN_CTRL_RESTART_EN
                    state_d  = RESTART;
`else
                    k_d      = '0;
                    araddr_c = phase_addr('0);
                    state_d  = READ;
`endif
                end else begin
                    cnt_d = cnt + 32'd1;
                end
            end
`ifdef ISING_RUN_CTRL_RESTART_EN
            RESTART: begin
                wr_en_c   = 1'b1;
                wr_addr_c = START_ADDR;
                wdata_c   = RESTART_WORD;
                cnt_d     = '0;
                state_d   = WAIT2;
            end
            WAIT2: begin
                if (cnt == 32'(RUN_CYCLES - 1)) begin
                    k_d      = '0;
                    araddr_c = phase_addr('0);
                    state_d  = READ;
                end else begin
                    cnt_d = cnt + 32'd1;
                end
            end
`endif
            READ: state_d = CAP;
            CAP: begin
                spins_d[k] = (rdata >= cutoff_q);
                if (32'(k) == 32'(N - 1)) begin
                    state_d = DONE;
                end else begin
                    k_d      = k + IW'(1);
                    araddr_c = phase_addr(k + IW'(1));
                    state_d  = READ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        err_d = err;
        if (go_acc) err_d = 1'b0;
        if (drop)   err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            phase_b   <= 1'b0;
            cnt       <= '0;
            k         <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cutoff_q  <= '0;
            ctr_max_q <= '0;
            cpl_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            spins     <= '0;
            err       <= 1'b0;
            wready    <= 1'b0;
            wr_addr   <= '0;
            wdata     <= '0;
            araddr_q  <= '0;
        end else begin
            state     <= state_d;
            phase_b   <= phase_b_d;
            cnt       <= cnt_d;
            k         <= k_d;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count     <= count_d;
            if (go_acc) begin
                cutoff_q  <= cutoff;
                ctr_max_q <= ctr_max;
            end
            cpl_ready <= (count_d != CW'(DEPTH));
            busy      <= (state_d != IDLE);
            done      <= (state_d == DONE);
            spins     <= spins_d;
            err       <= err_d;
            wready    <= wr_en_c;
            wr_addr   <= wr_addr_c;
            wdata     <= wdata_c;
            araddr_q  <= araddr_c;
        end
    end
endmodule

// File: tb/tb_ising_run_ctrl.sv
// Scoreboard bench for ising_run_ctrl with a behavioural phase-read port; an N=6 instance covers dropped entries.
module tb_ising_run_ctrl;
    localparam int unsigned N = 8, NW = 3, DEPTH = 16, RC = 20;
    localparam logic [31:0] WB = 32'h0001_0000, CUTA = 32'h4, MAXA = 32'h8, STA = 32'h0, PHB = 32'h100;
    localparam logic [31:0] START_W = 32'h10, RESTART_W = 32'h200;

    typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;

    logic clk = 1'b0, rst;
    logic cpl_valid, cpl_ready, go, busy, done, err, wready;
    logic [2:0] cpl_i, cpl_j, cpl_w;
    logic [31:0] cutoff, ctr_max, wr_addr, wdata, araddr_q, rdata;
    logic [N-1:0] spins;
    logic [31:0] phase_mem [8];
    logic [31:0] rd_off;

    logic v6, ready6, go6, busy6, done6, err6, wready6;
    logic [2:0] i6, j6, w6;
    logic [31:0] cut6, max6, waddr6, wdata6, raddr6, rdata6;
    logic [5:0] spins6;

    wr_t wq[$];
    logic [7:0] sq[$];
    int checks = 0, failures = 0, ndone = 0, nwrites = 0, n6writes = 0;

    always #51 clk = ~clk;

    ising_run_ctrl #(
        .N(N), .NUM_WEIGHTS(NW), .DEPTH(DEPTH), .RUN_CYCLES(RC), .START_WORD(START_W),
`ifdef ISING_RUN_CTRL_RESTART_EN
        .RESTART_WORD(RESTART_W),
`endif
        .WEIGHT_ADDR_BASE(WB), .CTR_CUTOFF_ADDR(CUTA), .CTR_MAX_ADDR(MAXA),
        .START_ADDR(STA), .PHASE_ADDR_BASE(PHB)
    ) dut (
        .clk(clk), .rst(rst), .cpl_valid(cpl_valid), .cpl_ready(cpl_ready),
        .cpl_i(cpl_i), .cpl_j(cpl_j), .cpl_w(cpl_w), .cutoff(cutoff), .ctr_max(ctr_max),
        .go(go), .busy(busy), .done(done), .spins(spins), .err(err), .wready(wready),
        .wr_addr(wr_addr), .wdata(wdata), .araddr_q(araddr_q), .rdata(rdata)
    );

    ising_run_ctrl #(
        .N(6), .NUM_WEIGHTS(NW), .DEPTH(DEPTH), .RUN_CYCLES(RC), .START_WORD(START_W),
`ifdef ISING_RUN_CTRL_RESTART_EN
        .RESTART_WORD(RESTART_W),
`endif
        .WEIGHT_ADDR_BASE(WB), .CTR_CUTOFF_ADDR(CUTA), .CTR_MAX_ADDR(MAXA),
        .START_ADDR(STA), .PHASE_ADDR_BASE(PHB)
    ) dut6 (
        .clk(clk), .rst(rst), .cpl_valid(v6), .cpl_ready(ready6),
        .cpl_i(i6), .cpl_j(j6), .cpl_w(w6), .cutoff(cut6), .ctr_max(max6),
        .go(go6), .busy(busy6), .done(done6), .spins(spins6), .err(err6), .wready(wready6),
        .wr_addr(waddr6), .wdata(wdata6), .araddr_q(raddr6), .rdata(rdata6)
    );

    // Read port model: data for the address presented one cycle earlier.
    assign rd_off = araddr_q - PHB;
    always @(posedge clk) rdata <= phase_mem[rd_off[4:2]];

    function automatic logic [31:0] wa(input int r, input int c);
        return WB + 32'(r * 4) + 32'(c * 8192);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_phase(input int s, input logic [31:0] v);
        phase_mem[N-1-s] = v;
    endtask

    task automatic push(input int i, input int j, input int w, output logic acc);
        acc = cpl_ready;
        cpl_i = 3'(i); cpl_j = 3'(j); cpl_w = 3'(w); cpl_valid = 1'b1;
        @(posedge clk); #1 cpl_valid = 1'b0;
        if (acc) begin
            wq.push_back('{wa(i, j), 32'(w)});
            if (i != j) wq.push_back('{wa(j, i), 32'(w)});
        end
    endtask

    task automatic launch(input logic [31:0] cut, input logic [31:0] mx, input logic [7:0] exp_spins);
        wq.push_back('{CUTA, cut});
        wq.push_back('{MAXA, mx});
        wq.push_back('{STA, START_W});
`ifdef ISING_RUN_CTRL_RESTART_EN
        wq.push_back('{STA, RESTART_W});
`endif
        sq.push_back(exp_spins);
        cutoff = cut; ctr_max = mx; go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        chk("busy_after_go", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input int target);
        for (int c = 0; c < 3000 && ndone < target; c++) @(negedge clk);
        chk("done_timeout", 32'(ndone >= target), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic acc;
        rst = 1'b1; cpl_valid = 1'b0; cpl_i = '0; cpl_j = '0; cpl_w = '0;
        go = 1'b0; cutoff = '0; ctr_max = '0;
        v6 = 1'b0; i6 = '0; j6 = '0; w6 = '0; go6 = 1'b0; cut6 = '0; max6 = '0; rdata6 = '0;
        for (int s = 0; s < 8; s++) phase_mem[s] = '0;
        fork
            begin : monitor
                logic [7:0] es;
                wr_t ew;
                forever begin
                    @(negedge clk);
                    if (!rst) begin
                        if (wready6) n6writes++;
                        if (wready) begin
                            nwrites++;
                            if (wq.size() == 0) begin
                                checks++; failures++;
                                $display("FAIL write_unexpected actual=%h/%h required=none", wr_addr, wdata);
                            end else begin
                                ew = wq.pop_front();
                                chk("write_addr", wr_addr, ew.a);
                                chk("write_data", wdata, ew.d);
                            end
                        end
                        if (done) begin
                            ndone++;
                            if (sq.size() == 0) begin
                                checks++; failures++;
                                $display("FAIL done_unexpected actual=%h required=none", spins);
                            end else begin
                                es = sq.pop_front();
                                chk("spins", 32'(spins), 32'(es));
                            end
                        end
                    end
                end
            end
            begin : main
                repeat (3) @(posedge clk);
                #1;
                chk("rst_busy", 32'(busy), 0);
                chk("rst_done", 32'(done), 0);
                chk("rst_spins", 32'(spins), 0);
                chk("rst_wready", 32'(wready), 0);
                chk("rst_cpl_ready", 32'(cpl_ready), 1);
                chk("rst_err", 32'(err), 0);
                rst = 1'b0;
                @(posedge clk); #1;

                // Mirrored pair, diagonal single write, then counter programming.
                for (int s = 0; s < 8; s++) set_phase(s, 32'(s));
                push(0, 1, 0, acc);
                push(3, 3, 2, acc);
                launch(32'd4, 32'd8, 8'hF0);
                wait_done(1);

                // Max-cut graph with phases chosen so A,C,D,H end up above the cutoff.
                set_phase(0, 32'd10); set_phase(1, 32'd3); set_phase(2, 32'd4); set_phase(3, 32'd100);
                set_phase(4, 32'd0);  set_phase(5, 32'd2); set_phase(6, 32'd1); set_phase(7, 32'hFFFF_FFFF);
                push(0, 1, 0, acc); push(0, 4, 0, acc); push(1, 2, 0, acc);
                push(1, 3, 0, acc); push(2, 3, 0, acc); push(3, 4, 0, acc);
                for (int s = 0; s < 5; s++) push(s, 7, 2, acc);
                launch(32'd4, 32'd8, 8'h8D);
                wait_done(2);

                // Fill the FIFO; the overflow entry must be refused.
                for (int s = 0; s < 8; s++) set_phase(s, 32'd0);
                for (int e = 0; e < 16; e++) push(e % 8, (e + 3) % 8, e % 3, acc);
                chk("full_ready", 32'(cpl_ready), 0);
                push(5, 6, 1, acc);
                chk("overflow_accepted", 32'(acc), 0);
                launch(32'd1, 32'h1234, 8'h00);
                wait_done(3);
                chk("ready_after_drain", 32'(cpl_ready), 1);

                // Reset during WAIT aborts the job with no done pulse.
                begin
                    int base;
                    base = nwrites;
                    launch(32'd0, 32'd5, 8'hFF);
                    for (int c = 0; c < 200 && nwrites < base + 3; c++) @(posedge clk);
                    chk("start_seen", 32'(nwrites >= base + 3), 1);
                end
                repeat (5) @(posedge clk);
                #1 rst = 1'b1;
                wq.delete(); sq.delete();
                #1;
                chk("abort_busy", 32'(busy), 0);
                chk("abort_wready", 32'(wready), 0);
                @(posedge clk); #1 rst = 1'b0;
                repeat (40) @(posedge clk);
                #1;
                chk("abort_no_done", 32'(ndone), 3);
                launch(32'd0, 32'd5, 8'hFF);
                wait_done(4);

                // Out-of-range index on the N=6 instance: dropped, flagged, cleared by go.
                i6 = 3'd6; j6 = 3'd2; w6 = 3'd1; v6 = 1'b1;
                @(posedge clk); #1 v6 = 1'b0;
                chk("err6_set", 32'(err6), 1);
                cut6 = 32'd0; max6 = 32'd3; go6 = 1'b1;
                @(posedge clk); #1 go6 = 1'b0;
                chk("err6_cleared", 32'(err6), 0);
                begin
                    int c;
                    for (c = 0; c < 3000 && !done6; c++) @(negedge clk);
                    chk("done6_seen", 32'(done6), 1);
                    chk("spins6", 32'(spins6), 32'h3F);
                end
`ifdef ISING_RUN_CTRL_RESTART_EN
                chk("writes6", 32'(n6writes), 4);
`else
                chk("writes6", 32'(n6writes), 3);
`endif
                repeat (3) @(posedge clk);
                #1;
                chk("wq_empty", 32'(wq.size()), 0);
                chk("sq_empty", 32'(sq.size()), 0);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        join
    end
endmodule
